// File: rtl/serial_divider_unit.sv
// Purpose: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Latency: o_valid XLEN+2 cycles after accept; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: single outstanding op; o_ready low until the result handshake completes or a flush.
module serial_divider_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_result_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched operation context
    logic            r_is_rem;
    logic            r_quot_neg;
    logic            r_rem_neg;
    logic [XLEN-1:0] r_dvsr;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;

    // Request decode (valid only while a request is being presented)
    logic            w_is_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_shortcut;
    logic [XLEN-1:0] w_short_res;
    logic            w_accept;

    // Iteration datapath
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    // Sign fixup
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_fix_res;

    // funct3[2] only separates the divide group from the multiply group,
    // and every request reaching this unit is a divide, so it carries no
    // information here.
    logic w_unused;
    assign w_unused = i_funct3[2];

    // Handshake outputs decode straight from the state register
    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_busy   = (r_state != S_IDLE);
    assign o_result = r_result;

    // A same-cycle flush cancels the accept entirely
    assign w_accept = i_valid && o_ready && !i_flush;

    // funct3[0]=1 selects the unsigned variants, funct3[1]=1 the remainder
    assign w_is_signed = ~i_funct3[0];
    assign w_a_neg     = w_is_signed & i_dividend[XLEN-1];
    assign w_b_neg     = w_is_signed & i_divisor[XLEN-1];
    assign w_a_mag     = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign w_b_mag     = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;

    // Architecturally defined corner cases bypass the iteration
    assign w_div_zero = (i_divisor == '0);
    assign w_ovf      = w_is_signed && (i_dividend == SMIN) && (i_divisor == '1);
    assign w_shortcut = w_div_zero || w_ovf;

    // Shortcut result: x/0 = all ones, x%0 = x; MIN/-1 = MIN, MIN%-1 = 0
    always_comb begin
        w_short_res = '0;
        if (w_div_zero) begin
            w_short_res = i_funct3[1] ? i_dividend : '1;
        end else if (w_ovf) begin
            w_short_res = i_funct3[1] ? '0 : i_dividend;
        end
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The shifted value is
    // always below 2*divisor, so the difference fits in XLEN bits.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvsr});
    assign w_diff    = w_shift[XLEN-1:0] - r_dvsr;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

    // Restore signs of the magnitude results and pick the requested one
    assign w_quo_fix = r_quot_neg ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix = r_rem_neg  ? (~r_rem + 1'b1) : r_rem;
    assign w_fix_res = r_is_rem ? w_rem_fix : w_quo_fix;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_next = w_shortcut ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (i_result_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (i_flush) begin
            w_next = S_IDLE;
        end
    end

    // Latch operand magnitudes and sign flags at accept, then iterate in CALC
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_is_rem   <= 1'b0;
            r_quot_neg <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_dvsr     <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_is_rem   <= i_funct3[1];
            r_quot_neg <= w_a_neg ^ w_b_neg;
            r_rem_neg  <= w_a_neg;
            r_dvsr     <= w_b_mag;
            r_quo      <= w_a_mag;
            r_rem      <= '0;
            r_cnt      <= CNT_LAST;
        end else if ((r_state == S_CALC) && !i_flush) begin
            r_quo      <= w_quo_nxt;
            r_rem      <= w_rem_nxt;
            r_cnt      <= r_cnt - CW'(1);
        end
    end

    // Result register: loaded by a shortcut accept or by the FIXUP cycle,
    // otherwise held so it stays stable through DONE backpressure
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result <= '0;
        end else if (w_accept && w_shortcut) begin
            r_result <= w_short_res;
        end else if ((r_state == S_FIXUP) && !i_flush) begin
            r_result <= w_fix_res;
        end
    end

endmodule

// File: tb/tb_serial_divider_unit.sv
// Purpose: directed check of serial_divider_unit results, latency, backpressure, flush and reset.
// Latency: counts cycles from the accept edge to the first o_valid sample.
// Backpressure: drives i_result_ready directly, including long stalls in DONE.
module tb_serial_divider_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        i_flush;
    logic        o_valid;
    logic        i_result_ready;
    logic [31:0] o_result;
    logic        o_busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    serial_divider_unit #(.XLEN(32)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_funct3       (i_funct3),
        .i_dividend     (i_dividend),
        .i_divisor      (i_divisor),
        .i_flush        (i_flush),
        .o_valid        (o_valid),
        .i_result_ready (i_result_ready),
        .o_result       (o_result),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns 1 time unit after the accept edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        i_valid    = 1'b1;
        i_funct3   = f;
        i_dividend = a;
        i_divisor  = b;
        @(posedge i_clk); #1;
        i_valid    = 1'b0;
    endtask

    // Cycle index (accept cycle = 0) at which o_valid is first seen, bounded
    task automatic wait_valid(output int lat);
        lat = 1;
        while (o_valid !== 1'b1 && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        i_result_ready = 1'b1;
        @(posedge i_clk); #1;
        i_result_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(f, a, b);
        wait_valid(lat);
        chk({tag, " result"}, o_result, exp_res);
        chk({tag, " latency"}, lat, exp_lat);
        take();
        chk({tag, " ready after handoff"}, {31'b0, o_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        i_rst          = 1'b1;
        i_valid        = 1'b0;
        i_funct3       = 3'b000;
        i_dividend     = '0;
        i_divisor      = '0;
        i_flush        = 1'b0;
        i_result_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Reset state
        chk("reset o_ready",  {31'b0, o_ready}, 32'd1);
        chk("reset o_valid",  {31'b0, o_valid}, 32'd0);
        chk("reset o_busy",   {31'b0, o_busy},  32'd0);
        chk("reset o_result", o_result,         32'd0);

        // Normal path, unsigned and signed
        run("DIVU 100/7",   F_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run("REMU 100/7",   F_REMU, 32'd100, 32'd7, 32'd2,  34);
        run("DIV -7/2",     F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run("REM -7/2",     F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run("DIV 7/-2",     F_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run("DIVU big/16",  F_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
        run("REMU big/16",  F_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 34);
        run("DIV MIN/3",    F_DIV,  32'h8000_0000, 32'd3, 32'hD555_5556, 34);
        run("REM MIN/3",    F_REM,  32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 34);
        run("funct3 b2 clr",3'b001, 32'd100, 32'd7, 32'd14, 34);

        // Divide by zero
        run("DIV 5/0",      F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("REMU 5/0",     F_REMU, 32'd5, 32'd0, 32'd5, 1);
        run("DIVU max/0",   F_DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1);

        // Signed overflow, and the same operands unsigned
        run("DIV MIN/-1",   F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("REM MIN/-1",   F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run("DIVU MIN/max", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

        // Input changes during CALC and requests while busy are ignored
        issue(F_DIVU, 32'd1000, 32'd10);
        i_dividend = 32'd5;
        i_divisor  = 32'd1;
        i_funct3   = F_REMU;
        i_valid    = 1'b1;
        chk("busy during calc", {31'b0, o_busy}, 32'd1);
        wait_valid(lat);
        i_valid = 1'b0;
        chk("bp result", o_result, 32'd100);
        chk("bp latency", lat, 34);
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            chk("bp hold o_valid", {31'b0, o_valid}, 32'd1);
            chk("bp hold o_result", o_result, 32'd100);
        end
        take();
        chk("bp ready after handoff", {31'b0, o_ready}, 32'd1);

        // Flush at CALC cycle 10
        issue(F_DIVU, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge i_clk); #1;
        end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        chk("flush o_busy",  {31'b0, o_busy},  32'd0);
        chk("flush o_ready", {31'b0, o_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid === 1'b1) seen++;
            @(posedge i_clk); #1;
        end
        chk("flush no o_valid", seen, 0);
        run("after flush DIVU 200/9", F_DIVU, 32'd200, 32'd9, 32'd22, 34);

        // Flush beats a same-cycle accept
        i_valid    = 1'b1;
        i_funct3   = F_DIV;
        i_dividend = 32'd5;
        i_divisor  = 32'd0;
        i_flush    = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush vs accept busy",  {31'b0, o_busy},  32'd0);
        chk("flush vs accept valid", {31'b0, o_valid}, 32'd0);

        // Flush in DONE together with the result handshake
        issue(F_DIVU, 32'd9, 32'd0);
        chk("done before flush", {31'b0, o_valid}, 32'd1);
        i_flush        = 1'b1;
        i_result_ready = 1'b1;
        @(posedge i_clk); #1;
        i_flush        = 1'b0;
        i_result_ready = 1'b0;
        chk("flush in done valid", {31'b0, o_valid}, 32'd0);
        chk("flush in done ready", {31'b0, o_ready}, 32'd1);

        // Reset mid-CALC clears the result register
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (5) begin
            @(posedge i_clk); #1;
        end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rst mid calc o_result", o_result, 32'd0);
        chk("rst mid calc o_ready",  {31'b0, o_ready}, 32'd1);
        chk("rst mid calc o_busy",   {31'b0, o_busy},  32'd0);
        run("after reset REMU 100/7", F_REMU, 32'd100, 32'd7, 32'd2, 34);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
